kf_matrix_wr_arbiter: RTL

Shares the single write port of the Kalman matrix bank (Q_k/R_k/P_00/P_k storage) between two requesters: the host side and the Kalman core.
- Host side: the AXI-Lite matrix loader's fire-and-forget wr_en pulses.
- Kalman core: P_k writeback with req/ack.
- Buffers host writes in a small FIFO and arbitrates round-robin; host is locked out while an iteration runs.
- Tracks per-matrix load completion so the core knows when Q/R/P_00 are fully loaded.

---
 rtl/kf_matrix_wr_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/kf_matrix_wr_arbiter.sv
// Write-port arbiter for the Kalman matrix bank: host FIFO plus core req/ack, round-robin, with load tracking.
// Define KF_ARB_STATS_EN to add the host_wr_cnt/core_wr_cnt handshake counters.
module kf_matrix_wr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int Q_DIM      = 12,
    parameter int R_DIM      = 6,
    parameter int P_DIM      = 12
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          host_wr_en,
    input  logic [DATA_WIDTH-1:0]         host_data,
    input  logic [9:0]                    host_row,
    input  logic [9:0]                    host_col,
    input  logic [1:0]                    host_sel,
    input  logic                          core_req,
    input  logic [DATA_WIDTH-1:0]         core_data,
    input  logic [9:0]                    core_row,
    input  logic [9:0]                    core_col,
    input  logic [1:0]                    core_sel,
    input  logic                          core_busy,
    output logic                          core_ack,
    output logic                          mem_wr_en,
    output logic [DATA_WIDTH-1:0]         mem_data,
    output logic [9:0]                    mem_row,
    output logic [9:0]                    mem_col,
    output logic [1:0]                    mem_sel,
    input  logic                          mem_ready,
    input  logic                          clr_loaded,
    output logic                          q_loaded,
    output logic                          r_loaded,
    output logic                          p_loaded,
    output logic                          host_ovf,
`ifdef KF_ARB_STATS_EN
    output logic [15:0]                   host_wr_cnt,
    output logic [15:0]                   core_wr_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 2 + 10 + 10 + DATA_WIDTH;

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic {OWN_HOST, OWN_CORE} owner_t;

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d, last_grant_q, last_grant_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic [9:0]              mem_row_q, mem_row_d, mem_col_q, mem_col_d;
    logic [1:0]              mem_sel_q, mem_sel_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          level_q, level_d;
    logic                    host_ovf_q, host_ovf_d;
    logic [ENT_W-1:0]        fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]        head;
    logic                    fifo_empty, fifo_full, push, pop, handshake, host_hs, core_hs;
    logic                    host_elig, core_elig, host_valid;
    logic [2:0]              loaded;

    assign head       = fifo_mem_q[rd_ptr_q];
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (PTR_W+1)'(FIFO_DEPTH));
    assign handshake  = mem_wr_en_q & mem_ready;
    assign host_hs    = handshake & (owner_q == OWN_HOST);
    assign core_hs    = handshake & (owner_q == OWN_CORE);
    assign host_valid = host_wr_en & (host_sel != 2'd3);
    assign host_elig  = ~fifo_empty & ~core_busy;
    assign core_elig  = core_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_wr_en_d  = mem_wr_en_q;
        mem_data_d   = mem_data_q;
        mem_row_d    = mem_row_q;
        mem_col_d    = mem_col_q;
        mem_sel_d    = mem_sel_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                // Host wins a tie only when the core had the previous grant.
                if (host_elig && (!core_elig || last_grant_q == OWN_CORE)) begin
                    mem_wr_en_d = 1'b1;
                    mem_sel_d   = head[ENT_W-1 -: 2];
                    mem_row_d   = head[DATA_WIDTH+19 -: 10];
                    mem_col_d   = head[DATA_WIDTH+9 -: 10];
                    mem_data_d  = head[DATA_WIDTH-1:0];
                    owner_d     = OWN_HOST;
                    pop         = 1'b1;
                    state_d     = ISSUE;
                end else if (core_elig) begin
                    mem_wr_en_d = 1'b1;
                    mem_sel_d   = core_sel;
                    mem_row_d   = core_row;
                    mem_col_d   = core_col;
                    mem_data_d  = core_data;
                    owner_d     = OWN_CORE;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    mem_wr_en_d  = 1'b0;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push       = host_valid & (~fifo_full | pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q;
        if (push && !pop)
            level_d = level_q + (PTR_W+1)'(1);
        else if (pop && !push)
            level_d = level_q - (PTR_W+1)'(1);
        host_ovf_d = clr_loaded ? 1'b0 : (host_ovf_q | (host_valid & fifo_full & ~pop));
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= IDLE;
            owner_q      <= OWN_HOST;
            last_grant_q <= OWN_CORE;
            mem_wr_en_q  <= 1'b0;
            mem_data_q   <= '0;
            mem_row_q    <= '0;
            mem_col_q    <= '0;
            mem_sel_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            host_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_data_q   <= mem_data_d;
            mem_row_q    <= mem_row_d;
            mem_col_q    <= mem_col_d;
            mem_sel_q    <= mem_sel_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            host_ovf_q   <= host_ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= {host_sel, host_row, host_col, host_data};
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_load
        localparam int DIM   = (gi == 0) ? Q_DIM : ((gi == 1) ? R_DIM : P_DIM);
        localparam int CNT_W = $clog2(DIM * DIM + 1);
        localparam logic [CNT_W-1:0] FULL  = CNT_W'(DIM * DIM);
        localparam logic [9:0]       DIM_L = 10'(DIM);
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             hit;

        always_comb begin
            hit   = host_hs && (mem_sel_q == 2'(gi)) && (mem_row_q < DIM_L) && (mem_col_q < DIM_L);
            cnt_d = cnt_q;
            if (clr_loaded)
                cnt_d = '0;
            else if (hit && cnt_q != FULL)
                cnt_d = cnt_q + CNT_W'(1);
        end

        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) cnt_q <= '0;
            else                cnt_q <= cnt_d;
        end

        assign loaded[gi] = (cnt_q == FULL);
    end

`ifdef KF_ARB_STATS_EN
    logic [15:0] host_wr_cnt_q, host_wr_cnt_d, core_wr_cnt_q, core_wr_cnt_d;

    always_comb begin
        host_wr_cnt_d = host_wr_cnt_q + 16'(host_hs);
        core_wr_cnt_d = core_wr_cnt_q + 16'(core_hs);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            host_wr_cnt_q <= '0;
            core_wr_cnt_q <= '0;
        end else begin
            host_wr_cnt_q <= host_wr_cnt_d;
            core_wr_cnt_q <= core_wr_cnt_d;
        end
    end

    assign host_wr_cnt = host_wr_cnt_q;
    assign core_wr_cnt = core_wr_cnt_q;
`endif

    assign core_ack   = core_hs;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_data   = mem_data_q;
    assign mem_row    = mem_row_q;
    assign mem_col    = mem_col_q;
    assign mem_sel    = mem_sel_q;
    assign q_loaded   = loaded[0];
    assign r_loaded   = loaded[1];
    assign p_loaded   = loaded[2];
    assign host_ovf   = host_ovf_q;
    assign fifo_level = level_q;

endmodule
